palette_mapper: RTL and testbench

- Parametrised, RAM-backed successor to the fixed colour-conversion logic. Maps per-pixel object flags (ball, paddles, scorefield) and a video mode to an RGB word through a host-programmable palette.
- Sits between the game core's object outputs and the video DAC/scan-doubler, in the clkvideo domain.
- Adds three things the fixed logic lacks: a pipelined registered output with sync delay matching, a palette write port with handshake, and blanked mode switching that only happens at a frame boundary.

---
 rtl/palette_mapper.sv | 179 +++++++++++++++++
 tb/tb_palette_mapper.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_mapper.sv
// Palette mapper: object flags + video mode -> RGB via a programmable palette RAM.
// Ports: clkvideo/rst_n, obj/hsync_in/vsync_in/vmode in, pal_wr_* write port, rgb_out/hsync_out/vsync_out/init_done out.
module palette_mapper #(
  parameter int N_OBJ        = 4,
  parameter int MODE_W       = 4,
  parameter int CH_W         = 4,
  parameter int BLANK_FRAMES = 2,
  localparam int IDX_W = $clog2(N_OBJ + 1),
  localparam int AW    = MODE_W + IDX_W,
  localparam int RGB_W = 3 * CH_W
) (
  input  logic              clkvideo,
  input  logic              rst_n,
  input  logic [N_OBJ-1:0]  obj,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [MODE_W-1:0] vmode,
  input  logic              pal_wr_valid,
  output logic              pal_wr_ready,
  input  logic [AW-1:0]     pal_wr_addr,
  input  logic [RGB_W-1:0]  pal_wr_data,
  output logic [RGB_W-1:0]  rgb_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              init_done
);

  localparam int DEPTH = 1 << AW;
  localparam int BW =
    (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e state_q, state_d;
  logic [AW-1:0] init_addr_q, init_addr_d;
  logic init_done_q, init_done_d;

  logic we;
  logic [AW-1:0] wa;
  logic [RGB_W-1:0] wd;

  logic [IDX_W-1:0] idx;

  logic vs_prev_q, vs_prev_d;
  logic vs_rise;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [BW-1:0] blank_q, blank_d;

  logic [AW-1:0] a1_q, a1_d;
  logic hs1_q, hs1_d;
  logic vs1_q, vs1_d;
  logic hs2_q, hs2_d;
  logic vs2_q, vs2_d;
  logic hs3_q, hs3_d;
  logic vs3_q, vs3_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic [RGB_W-1:0] rd_data_q;

  logic [RGB_W-1:0] mem [DEPTH];

  // Ready only once the fill has been observed complete,
  // so host writes can never collide with the default fill.
  assign pal_wr_ready = init_done_q;

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    we          = 1'b0;
    wa          = pal_wr_addr;
    wd          = pal_wr_data;
    unique case (state_q)
      S_INIT: begin
        we = 1'b1;
        wa = init_addr_q;
        wd = (init_addr_q[IDX_W-1:0] == '0) ? '0 : '1;
        if (init_addr_q == AW'(DEPTH - 1)) begin
          state_d = S_RUN;
        end else begin
          init_addr_d = init_addr_q + 1'b1;
        end
      end
      S_RUN: begin
        we = pal_wr_valid && pal_wr_ready;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  assign init_done_d = (state_q == S_RUN);

  // Lowest set bit wins: scan from the top so lower bits overwrite.
  always_comb begin
    idx = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (obj[i]) idx = IDX_W'(i + 1);
    end
  end

  assign vs_rise = vsync_in && !vs_prev_q;

  always_comb begin
    vs_prev_d = vsync_in;
    mode_d    = mode_q;
    blank_d   = blank_q;
    if (vs_rise) begin
      mode_d = vmode;
      if (BLANK_FRAMES > 0 && vmode != mode_q) begin
        blank_d = BW'(BLANK_FRAMES);
      end else if (blank_q != '0) begin
        blank_d = blank_q - 1'b1;
      end
    end
  end

  always_comb begin
    a1_d  = {mode_q, idx};
    hs1_d = hsync_in;
    vs1_d = vsync_in;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    hs3_d = hs2_q;
    vs3_d = vs2_q;
    rgb_d = rd_data_q;
    if (hs2_q || blank_q != '0 || !init_done_q) begin
      rgb_d = '0;
    end
  end

  // Palette RAM: read returns pre-write data on a same-edge hit.
  always_ff @(posedge clkvideo) begin
    if (we) mem[wa] <= wd;
    rd_data_q <= mem[a1_q];
  end

  always_ff @(posedge clkvideo or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
      vs_prev_q   <= 1'b0;
      mode_q      <= '0;
      blank_q     <= '0;
      a1_q        <= '0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      hs2_q       <= 1'b0;
      vs2_q       <= 1'b0;
      hs3_q       <= 1'b0;
      vs3_q       <= 1'b0;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      init_done_q <= init_done_d;
      vs_prev_q   <= vs_prev_d;
      mode_q      <= mode_d;
      blank_q     <= blank_d;
      a1_q        <= a1_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      hs2_q       <= hs2_d;
      vs2_q       <= vs2_d;
      hs3_q       <= hs3_d;
      vs3_q       <= vs3_d;
      rgb_q       <= rgb_d;
    end
  end

  assign rgb_out   = rgb_q;
  assign hsync_out = hs3_q;
  assign vsync_out = vs3_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_palette_mapper.sv
// Testbench for palette_mapper: random traffic against a reference model,
// scoreboard queue filled at stimulus time and drained by a monitor.
module tb_palette_mapper;

  localparam int DEPTH = 128;

  logic        clkvideo = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  obj = '0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [3:0]  vmode = '0;
  logic        pal_wr_valid = 1'b0;
  logic        pal_wr_ready;
  logic [6:0]  pal_wr_addr = '0;
  logic [11:0] pal_wr_data = '0;
  logic [11:0] rgb_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        init_done;

  always #5 clkvideo = ~clkvideo;

  palette_mapper dut (
    .clkvideo    (clkvideo),
    .rst_n       (rst_n),
    .obj         (obj),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .vmode       (vmode),
    .pal_wr_valid(pal_wr_valid),
    .pal_wr_ready(pal_wr_ready),
    .pal_wr_addr (pal_wr_addr),
    .pal_wr_data (pal_wr_data),
    .rgb_out     (rgb_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .init_done   (init_done)
  );

  typedef struct {
    logic [6:0]  addr;
    logic        hs;
    logic        vs;
    logic [11:0] rd;
  } pix_t;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  pix_t pend[$];
  exp_t exp_q[$];
  exp_t mon_e;

  logic [11:0] m_pal [DEPTH];
  logic [3:0]  m_mode;
  int          m_blank;
  int          m_cnt;
  bit          m_done;
  logic        m_vprev;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_idx(logic [3:0] o);
    for (int i = 0; i < 4; i++) begin
      if (o[i]) return 3'(i + 1);
    end
    return 3'd0;
  endfunction

  task automatic model_reset();
    pix_t z;
    z.addr = '0;
    z.hs = 1'b0;
    z.vs = 1'b0;
    z.rd = '0;
    for (int a = 0; a < DEPTH; a++) begin
      m_pal[a] = (a % 8 == 0) ? 12'h000 : 12'hFFF;
    end
    pend.delete();
    exp_q.delete();
    pend.push_back(z);
    pend.push_back(z);
    m_mode  = '0;
    m_blank = 0;
    m_cnt   = 0;
    m_done  = 1'b0;
    m_vprev = 1'b0;
  endtask

  // One clock edge of the reference: pixel enters, palette is looked up
  // one edge later, colour is decided one edge after that.
  task automatic model_step();
    pix_t old_p, mid_p, new_p;
    exp_t e;
    old_p = pend.pop_front();
    mid_p = pend.pop_front();
    e.rgb = (old_p.hs || m_blank != 0 || !m_done) ? 12'h000 : old_p.rd;
    e.hs  = old_p.hs;
    e.vs  = old_p.vs;
    exp_q.push_back(e);
    mid_p.rd = m_pal[mid_p.addr];
    pend.push_back(mid_p);
    new_p.addr = {m_mode, ref_idx(obj)};
    new_p.hs   = hsync_in;
    new_p.vs   = vsync_in;
    new_p.rd   = '0;
    pend.push_back(new_p);
    if (m_done && pal_wr_valid) m_pal[pal_wr_addr] = pal_wr_data;
    if (vsync_in && !m_vprev) begin
      if (vmode != m_mode) m_blank = 2;
      else if (m_blank > 0) m_blank--;
      m_mode = vmode;
    end
    m_vprev = vsync_in;
    m_cnt++;
    m_done = (m_cnt >= DEPTH + 1);
  endtask

  task automatic tick();
    @(posedge clkvideo);
    if (rst_n) model_step();
    @(negedge clkvideo);
  endtask

  always @(negedge clkvideo) begin
    if (!rst_n) begin
      chk("rst_rgb", 32'(rgb_out), 32'h0);
      chk("rst_sync", 32'({hsync_out, vsync_out}), 32'h0);
      chk("rst_flags", 32'({init_done, pal_wr_ready}), 32'h0);
    end else begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("rgb", 32'(rgb_out), 32'(mon_e.rgb));
        chk("sync", 32'({hsync_out, vsync_out}),
            32'({mon_e.hs, mon_e.vs}));
      end
      chk("init_done", 32'(init_done), 32'(m_done));
      chk("wr_ready", 32'(pal_wr_ready), 32'(m_done));
    end
  end

  task automatic measure_init();
    int n;
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (init_done) begin
        n = i;
        break;
      end
    end
    chk("init_latency", 32'(n), 32'(DEPTH + 1));
  endtask

  task automatic do_write(logic [6:0] a, logic [11:0] d);
    logic acc;
    acc = 1'b0;
    pal_wr_addr  = a;
    pal_wr_data  = d;
    pal_wr_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      acc = pal_wr_ready;
      tick();
      if (acc) break;
    end
    pal_wr_valid = 1'b0;
    chk("wr_accept", 32'(acc), 32'h1);
  endtask

  task automatic hold(logic [3:0] o, logic hs, int n);
    obj = o;
    hsync_in = hs;
    repeat (n) tick();
  endtask

  task automatic frame(int len);
    for (int i = 0; i < len; i++) begin
      obj      = 4'($urandom);
      hsync_in = ((i % 20) >= 17);
      vsync_in = (i >= len - 3);
      tick();
    end
    vsync_in = 1'b0;
    hsync_in = 1'b0;
  endtask

  task automatic assert_reset();
    @(posedge clkvideo);
    if (rst_n) model_step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rgb", 32'(rgb_out), 32'h0);
    chk("async_sync", 32'({hsync_out, vsync_out}), 32'h0);
    chk("async_flags", 32'({init_done, pal_wr_ready}), 32'h0);
    @(negedge clkvideo);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    pal_wr_valid = 1'b1;
    pal_wr_addr  = 7'h01;
    pal_wr_data  = 12'h123;
    obj          = 4'b0001;
    repeat (3) @(negedge clkvideo);
    #2;
    rst_n = 1'b1;

    // Write held through release: accepted on the first ready edge.
    measure_init();
    tick();
    pal_wr_valid = 1'b0;
    hold(4'b0001, 1'b0, 6);
    do_write(7'h01, 12'hFFF);

    hold(4'b0001, 1'b0, 5);
    hold(4'b0000, 1'b0, 5);
    hold(4'b1010, 1'b0, 5);
    repeat (100) begin
      obj      = 4'($urandom);
      hsync_in = ($urandom_range(0, 7) == 0);
      tick();
    end
    hsync_in = 1'b0;

    do_write({4'd3, 3'd2}, 12'h0F0);
    vmode = 4'd3;
    repeat (20) begin
      obj = 4'($urandom);
      tick();
    end
    frame(40);
    frame(40);
    frame(40);
    hold(4'b0110, 1'b0, 5);
    hold(4'b0110, 1'b1, 4);
    hold(4'b0110, 1'b0, 4);

    // Second change while blanking restarts the count.
    vmode = 4'd0;
    frame(40);
    vmode = 4'd5;
    frame(40);
    frame(40);
    frame(40);
    frame(30);

    repeat (6) begin
      vmode = ($urandom_range(0, 2) == 0) ? vmode : 4'($urandom);
      repeat (4) do_write(7'($urandom), 12'($urandom));
      frame(60);
    end

    assert_reset();
    repeat (51) tick();
    assert_reset();
    measure_init();
    frame(40);
    vmode = 4'd9;
    frame(40);
    frame(40);
    frame(40);

    obj = '0;
    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
